// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared 1-bit adder slice is stepped over
// WIDTH cycles, LSB first, to form {cout, sum} = a + b + cin.

// Half-adder cell; the adder slice is built from two of these plus an OR.
module serial_add_half (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, sum_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s0, c0, s1, c1, slice_s, slice_c;
  logic             last_bit;

  // 1-bit full-adder slice: two half adders, carries ORed
  serial_add_half u_ha0 (.x(op_a[0]), .y(op_b[0]), .s(s0), .c(c0));
  serial_add_half u_ha1 (.x(s0),      .y(carry),   .s(s1), .c(c1));
  assign slice_s = s1;
  assign slice_c = c0 | c1;

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at sum[0]
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = slice_s;
    end else begin : g_wn
      assign sum_shift = {slice_s, sum[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Status comes straight from the state register; no path from start
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift one bit per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a  <= a;
          op_b  <= b;
          carry <= cin;
          cnt   <= '0;
          sum   <= '0;
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= slice_c;
          cnt   <= cnt + 1'b1;
          sum   <= sum_shift;
          if (last_bit) cout <= slice_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a WIDTH=8 instance and a WIDTH=1 instance.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start1, a1, b1, cin1;
  logic       busy1, done1, sum1, cout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one add on the 8-bit DUT; lat = negedges after the accept edge
  // until done is seen (done is high in the cycle after edge k+WIDTH).
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      output logic [7:0] rs, output logic rc, output int lat);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    rs = sum; rc = cout;
    if (lat < 0) chk("run8_timeout", 32'd0, 32'd1);
  endtask

  task automatic run1(input logic ia, input logic ib, input logic ic,
                      output logic rs, output logic rc, output int lat);
    @(negedge clk);
    a1 = ia; b1 = ib; cin1 = ic; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (done1) begin lat = i; break; end
    end
    rs = sum1; rc = cout1;
    if (lat < 0) chk("run1_timeout", 32'd0, 32'd1);
  endtask

  typedef struct { logic [7:0] a, b; logic c; logic [7:0] s; logic co; } vec_t;

  initial begin
    logic [7:0] rs;
    logic       rc, rs1;
    int         lat, ndone, last_d, prev_d;
    logic [8:0] ref9;
    logic [1:0] ref2;
    vec_t       vt[4];

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);   chk("rst_cout", cout, 0);
    @(negedge clk); rst = 1'b0;

    // Basic add with latency and busy check
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_busy", busy, 1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    chk("t1_latency", lat, 8);
    chk("t1_sum", sum, 8'h96); chk("t1_cout", cout, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0); chk("t1_idle", busy, 0);

    // Carry boundary vectors
    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vt[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    foreach (vt[i]) begin
      run8(vt[i].a, vt[i].b, vt[i].c, rs, rc, lat);
      chk($sformatf("vec%0d_sum", i), rs, vt[i].s);
      chk($sformatf("vec%0d_cout", i), rc, vt[i].co);
    end

    // Start during RUN must be ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; rs = '0; rc = 1'b1; lat = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin ndone++; rs = sum; rc = cout; end
      if (!busy && ndone == 0) lat = 1;
      @(negedge clk);
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_busy_gap", lat, 0);
    chk("ign_sum", rs, 8'h46); chk("ign_cout", rc, 0);

    // Start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    ndone = 0; last_d = -1; prev_d = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        if (prev_d) chk("cont_back2back", 1, 0);
        if (last_d >= 0) chk("cont_period", i - last_d, 10);
        chk("cont_sum", sum, 8'h00); chk("cont_cout", cout, 1);
        last_d = i; ndone++;
      end
      prev_d = done;
    end
    chk("cont_done_count", ndone >= 4, 1);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Hold check: result stable between done and next accept
    run8(8'hA5, 8'h0F, 1'b1, rs, rc, lat);
    chk("hold_pre_sum", rs, 8'hB5);
    a = 8'h11; b = 8'h22; cin = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_sum", sum, 8'hB5); chk("hold_cout", cout, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 8'hFF; b = 8'h00; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_pre_sum_nz", sum != 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);   chk("arst_cout", cout, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (15) begin @(negedge clk); if (done) ndone++; end
    chk("arst_no_done", ndone, 0);
    run8(8'h0F, 8'h01, 1'b0, rs, rc, lat);
    chk("arst_after_sum", rs, 8'h10); chk("arst_after_cout", rc, 0);

    // Random sweep against a+b+cin
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb; logic rcin;
      ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rcin};
      run8(ra, rb, rcin, rs, rc, lat);
      chk($sformatf("rnd%0d", i), {23'd0, rc, rs}, {23'd0, ref9});
    end

    // WIDTH=1 instance: all eight input combinations
    for (int i = 0; i < 8; i++) begin
      ref2 = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
      run1(i[0], i[1], i[2], rs1, rc, lat);
      chk($sformatf("w1_%0d_res", i), {rc, rs1}, ref2);
      chk($sformatf("w1_%0d_lat", i), lat, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
